// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
//   Writer side of the instruction path. Instruction fields arriving on a
//   valid/ready stream are packed into 8-bit words {op, operand}, buffered in
//   a small FIFO and written one per cycle into instruction memory, starting
//   at address 0. The CPU is held while a program is being loaded and is
//   released once the last word has landed in memory.
//
// Parameters
//   ADDR_W      instruction memory address width; capacity MAX = 2**ADDR_W
//   FIFO_DEPTH  input buffer entries (power of two, >= 2)
//
// Ports
//   clk, rst_n         clock (rising edge), synchronous active-low reset
//   start              begin a load session (honoured in IDLE or DONE only)
//   in_valid/in_ready  input stream handshake
//   in_op, in_operand  instruction fields; in_last marks the final word
//   imem_we/addr/wdata registered instruction memory write port
//   cpu_hold           1 keeps the CPU from fetching/executing
//   busy, done         session status (LOAD/DRAIN, DONE)
//   count              words written in the current session
//   err_overflow       sticky: program ran past MAX words without in_last
// -----------------------------------------------------------------------------
module instr_loader #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [4:0]        in_operand,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [7:0]        imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err_overflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]      occ_q, occ_d;
  logic [CNT_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                err_q, err_d;
  logic                imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic [7:0]          imem_wdata_q, imem_wdata_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                fifo_empty;
  logic                fifo_full;
  logic                ready_w;
  logic                push;
  logic                pop;
  logic [7:0]          push_word;

  // Handshake is a function of registered state only, so in_ready never
  // depends combinationally on in_valid.
  assign fifo_empty = (occ_q == '0);
  assign fifo_full  = (occ_q == FIFO_FULL);
  assign ready_w    = (state_q == ST_LOAD) && !fifo_full && (acc_q < MAX_WORDS);
  assign push       = in_valid && ready_w;
  assign pop        = ((state_q == ST_LOAD) || (state_q == ST_DRAIN)) && !fifo_empty;
  assign push_word  = {in_op, in_operand};

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    occ_d        = occ_q;
    acc_d        = acc_q;
    count_d      = count_q;
    err_d        = err_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      acc_d    = acc_q + CNT_W'(1);
    end

    // Pop stage: the head word becomes the registered memory write next cycle.
    // count doubles as the write address because the address never wraps.
    if (pop) begin
      rd_ptr_d     = rd_ptr_q + PTR_W'(1);
      imem_we_d    = 1'b1;
      imem_addr_d  = count_q[ADDR_W-1:0];
      imem_wdata_d = fifo_mem_q[rd_ptr_q];
      count_d      = count_q + CNT_W'(1);
    end

    unique case ({push, pop})
      2'b10:   occ_d = occ_q + (PTR_W + 1)'(1);
      2'b01:   occ_d = occ_q - (PTR_W + 1)'(1);
      default: occ_d = occ_q;
    endcase

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_LOAD;
          acc_d   = '0;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (push && in_last) begin
          state_d = ST_DRAIN;
        end else if (push && (acc_q == MAX_WORDS - CNT_W'(1))) begin
          // Capacity reached without a terminating word.
          state_d = ST_DRAIN;
          err_d   = 1'b1;
        end
      end
      ST_DRAIN: begin
        // Wait for the buffer to empty and the final write cycle to retire.
        if (fifo_empty && !imem_we_q) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Status outputs are registered from the next state.
    cpu_hold_d = (state_d != ST_DONE);
    busy_d     = (state_d == ST_LOAD) || (state_d == ST_DRAIN);
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      acc_q        <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_hold_q   <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      acc_q        <= acc_d;
      count_q      <= count_d;
      err_q        <= err_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_hold_q   <= cpu_hold_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Buffer storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= push_word;
    end
  end

  assign in_ready     = ready_w;
  assign imem_we      = imem_we_q;
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign cpu_hold     = cpu_hold_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign count        = count_q;
  assign err_overflow = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_loader
//   Randomized bench for instr_loader built with ADDR_W=3 (capacity 8) so the
//   overflow boundary is reachable. A reference model tracks accepted words in
//   a queue and expects them to appear on the memory port in order, at
//   consecutive addresses from 0, exactly two edges after acceptance.
// -----------------------------------------------------------------------------
module tb_instr_loader;

  localparam int AW  = 3;
  localparam int MAX = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [4:0]    in_operand;
  logic          in_last;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [7:0]    imem_wdata;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic [AW:0]   count;
  logic          err_overflow;

  instr_loader #(.ADDR_W(AW), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_operand   (in_operand),
    .in_last      (in_last),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .count        (count),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model state
  typedef struct {
    logic [7:0] w;
    int         c;
  } acc_t;

  acc_t       aq[$];
  acc_t       e_m;
  int         wr_idx = 0;
  int         acc_n  = 0;
  bit         sess   = 0;
  logic [7:0] mem_obs [MAX];
  logic [7:0] prog_w[$];

  always @(negedge clk) begin
    if (imem_we) begin
      chk("we_has_word", 32'(aq.size() > 0), 32'd1);
      if (aq.size() > 0) begin
        e_m = aq.pop_front();
        chk("waddr", 32'(imem_addr), 32'(wr_idx));
        chk("wdata", 32'(imem_wdata), 32'(e_m.w));
        chk("wlat", 32'(cyc - e_m.c), 32'd2);
        mem_obs[imem_addr] = imem_wdata;
        wr_idx++;
      end
    end
    if (!rst_n) begin
      aq.delete();
      wr_idx = 0;
      acc_n  = 0;
      sess   = 0;
    end else begin
      if (in_valid && in_ready) begin
        chk("acc_lim", 32'(acc_n < MAX), 32'd1);
        aq.push_back('{w: {in_op, in_operand}, c: cyc});
        acc_n++;
      end
      if (done) sess = 0;
      if (start && !sess) begin
        aq.delete();
        wr_idx = 0;
        acc_n  = 0;
        sess   = 1;
      end
    end
  end

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input bit last, output bit ok, output int waited);
    in_op      = w[7:5];
    in_operand = w[4:0];
    in_last    = last;
    in_valid   = 1'b1;
    ok         = 0;
    waited     = 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
      waited++;
    end
    @(posedge clk); #1;
  endtask

  // Sends prog_w[0..n-1]; the last word carries in_last unless no_last.
  task automatic run_prog(input int n, input bit no_last, input int gap_max, input bit poke_start);
    bit ok;
    int waited;
    int g;
    int exp_n;
    exp_n = (n > MAX) ? MAX : n;
    for (int i = 0; i < n; i++) begin
      if (gap_max > 0) begin
        g = $urandom_range(0, gap_max);
        in_valid = 1'b0;
        repeat (g) begin
          if (poke_start && ($urandom_range(0, 3) == 0)) start = 1'b1;
          @(posedge clk); #1 start = 1'b0;
        end
      end
      send_word(prog_w[i], !no_last && (i == n - 1), ok, waited);
      if (i < MAX) begin
        chk("acc_ok", 32'(ok), 32'd1);
        chk("acc_stall", 32'(waited), 32'd0);
      end else begin
        chk("ovf_rdy", 32'(ok), 32'd0);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int t = 0; t < 60; t++) begin
      if (done) break;
      @(negedge clk);
    end
    chk("done", 32'(done), 32'd1);
    chk("count", 32'(count), 32'(exp_n));
    chk("err_overflow", 32'(err_overflow), 32'(no_last));
    chk("n_writes", 32'(wr_idx), 32'(exp_n));
    chk("cpu_hold_rel", 32'(cpu_hold), 32'd0);
    chk("busy_done", 32'(busy), 32'd0);
    chk("ready_done", 32'(in_ready), 32'd0);
  endtask

  task automatic rand_prog(input int n);
    prog_w.delete();
    for (int i = 0; i < n; i++) prog_w.push_back(8'($urandom));
  endtask

  initial begin
    bit ok;
    int waited;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_op = '0; in_operand = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", 32'(imem_wdata), 32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_err", 32'(err_overflow), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Three-word program, in_valid held high throughout
    prog_w = '{8'h25, 8'h43, 8'h80};
    do_start();
    @(negedge clk);
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_hold", 32'(cpu_hold), 32'd1);
    @(posedge clk); #1;
    run_prog(3, 0, 0, 0);
    chk("mem0", 32'(mem_obs[0]), 32'h25);
    chk("mem1", 32'(mem_obs[1]), 32'h43);
    chk("mem2", 32'(mem_obs[2]), 32'h80);

    // Single-word program
    prog_w = '{8'hFF};
    do_start();
    run_prog(1, 0, 0, 0);
    chk("mem0_single", 32'(mem_obs[0]), 32'hFF);

    // Random programs with gaps and stray start pulses during LOAD
    for (int k = 0; k < 8; k++) begin
      rand_prog($urandom_range(1, MAX));
      do_start();
      run_prog(prog_w.size(), 0, 3, 1);
    end

    // Overflow: nine words, no terminator
    rand_prog(MAX + 1);
    do_start();
    run_prog(MAX + 1, 1, 0, 0);
    chk("ovf_mem_last", 32'(mem_obs[MAX-1]), 32'(prog_w[MAX-1]));

    // Restart from DONE
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_hold", 32'(cpu_hold), 32'd1);
    chk("restart_count", 32'(count), 32'd0);
    chk("restart_err", 32'(err_overflow), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rand_prog(4);
    run_prog(4, 0, 1, 0);

    // Reset after the second accepted word of five
    rand_prog(5);
    do_start();
    send_word(prog_w[0], 0, ok, waited);
    chk("mid_acc0", 32'(ok), 32'd1);
    send_word(prog_w[1], 0, ok, waited);
    chk("mid_acc1", 32'(ok), 32'd1);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_we", 32'(imem_we), 32'd0);
    chk("mid_hold", 32'(cpu_hold), 32'd1);
    chk("mid_count", 32'(count), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_ready", 32'(in_ready), 32'd0);
    repeat (4) begin
      @(negedge clk);
      chk("mid_quiet", 32'(imem_we), 32'd0);
    end
    rand_prog(3);
    do_start();
    run_prog(3, 0, 2, 0);
    chk("reload_mem0", 32'(mem_obs[0]), 32'(prog_w[0]));

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Writer side of the instruction path: accepts instruction fields (3-bit opcode, 5-bit operand) over a valid/ready stream and packs them into 8-bit instruction words.
- Buffers the words in a small FIFO and writes them sequentially into instruction memory starting at address 0.
- Holds the CPU (fetch/control unit) in hold while loading and releases it when the program is complete.
- Sits between the host/test loader and the instruction memory write port.

Parameters:
- ADDR_W, 8, instruction memory address width; capacity MAX = 2^ADDR_W words.
- FIFO_DEPTH, 4, input buffer entries; power of two, at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  begin a load session; sampled only in IDLE or DONE.
- in_valid  in  1  in_op, in_operand and in_last are valid.
- in_ready  out  1  loader accepts this cycle.
- in_op  in  3  opcode field; 000 ACM, 001 ACMI, 010 ADD, 011 NAND, 100 BNZ, 101 SLT, 110 SW, 111 LW.
- in_operand  in  5  register/immediate field.
- in_last  in  1  marks the final instruction of the program.
- imem_we  out  1  instruction memory write enable.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  8  instruction word = {in_op, in_operand}.
- cpu_hold  out  1  1 keeps the CPU from fetching/executing.
- busy  out  1  1 in LOAD or DRAIN.
- done  out  1  1 in DONE.
- count  out  ADDR_W+1  number of words written this session.
- err_overflow  out  1  sticky; program exceeded MAX words.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State IDLE; FIFO emptied; accept counter and write address cleared.
  - in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, busy=0, done=0, count=0, err_overflow=0.
  - Reset mid-session aborts immediately; no further writes occur.
- Handshake:
  - Transfer occurs when in_valid=1 and in_ready=1 at a clk edge.
  - in_ready = (state==LOAD) and FIFO not full and accepted < MAX. It is derived only from registered state, never from in_valid.
  - Data must be held by the sender until the transfer.
- Encoding: pushed word = {in_op, in_operand}, bit 7 = op[2]. No opcode filtering; all 8 opcodes are legal.
- FSM IDLE -> LOAD -> DRAIN -> DONE:
  - IDLE: cpu_hold=1. start=1 -> LOAD; count, write address and err_overflow cleared.
  - LOAD: accepts words.
    - Accepted word with in_last=1 -> DRAIN.
    - Accepted count reaching MAX without last -> DRAIN with err_overflow=1.
  - DRAIN: in_ready=0. FIFO empty and no write pending -> DONE.
  - DONE: cpu_hold=0, done=1, busy=0. Held until start=1, which restarts exactly as from IDLE (cpu_hold returns to 1 the next cycle).
  - start in LOAD or DRAIN is ignored.
- Write pipeline:
  - Each cycle the FIFO is non-empty in LOAD or DRAIN, the head is popped.
  - Next cycle: imem_we=1, imem_addr = write address, imem_wdata = popped word. Write address and count then increment.
  - imem_we, imem_addr and imem_wdata are registers.
  - Minimum latency: word accepted at edge N is written (imem_we high) in the cycle after edge N+1.
  - Sustained throughput: 1 word/cycle.
- Push and pop in the same cycle are both allowed. Occupancy is unchanged; no bypass of an empty FIFO.
- When no write is due, imem_we=0. imem_addr/imem_wdata hold their last values.
- Write address never wraps. Words beyond MAX are not accepted; the sender sees in_ready=0 and must stop.
- A one-word program (first word has last=1) is legal: count=1, written at address 0.
- After overflow, DONE is reached with count=MAX and err_overflow=1. cpu_hold is still released; software checks err_overflow.

Test Plan:
- Reset then start, stream 3 words (op,operand) = (001,00101), (010,00011), (100,00000, last) with in_valid held high -> writes 0x25@0, 0x43@1, 0x80@2 on consecutive cycles; count=3; done=1; cpu_hold=0; err_overflow=0.
- Single word (111,11111, last) -> one write 0xFF@0; DONE reached; count=1.
- FIFO backpressure: force FIFO full by toggling start timing and holding a sender with gaps -> in_ready drops when 4 entries are held; no word lost or duplicated; addresses contiguous.
- ADDR_W=3 build, send 9 words with no last -> 8 writes to addresses 0..7; in_ready=0 after the 8th accept; err_overflow=1; count=8; done=1.
- Assert rst_n=0 for one cycle after the 2nd accepted word of 5 -> imem_we=0 from the next cycle; state IDLE; cpu_hold=1; count=0; a new start reloads from address 0.
- start pulsed during LOAD -> ignored, session unaffected. start in DONE -> done=0, cpu_hold=1, count=0 next cycle.
